// File: rtl/spi_bus_arbiter.sv
// Shares one SPI bus between NREQ requesters: round-robin grant, one LSB-first
// full-duplex WORDLEN-bit transfer per grant, in the granted requester's SPI mode.
module spi_bus_arbiter #(
  parameter int unsigned WORDLEN = 8,
  parameter int unsigned NREQ    = 2,
  parameter int unsigned CLKDIV  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WORDLEN-1:0]   req_data,
  input  logic [2*NREQ-1:0]         req_mode,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic [WORDLEN-1:0]        rx_data,
  output logic                      busy,
  output logic                      SCLK,
  output logic                      MOSI,
  output logic [NREQ-1:0]           SS,
  input  logic                      MISO
);

  localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW    = $clog2(CLKDIV + 1);
  localparam int unsigned NEDGE = 2 * WORDLEN;
  localparam int unsigned EW    = $clog2(NEDGE + 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t               state_q;
  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        idx_q;
  logic [NREQ-1:0]      gnt_q;
  logic [NREQ-1:0]      done_q;
  logic [NREQ-1:0]      ss_q;
  logic [WORDLEN-1:0]   tx_q;
  logic [WORDLEN-1:0]   rx_q;
  logic [WORDLEN-1:0]   rx_data_q;
  logic                 cpha_q;
  logic                 sclk_q;
  logic                 mosi_q;
  logic                 busy_q;
  logic [CW-1:0]        cnt_q;
  logic [EW-1:0]        edge_q;

  // Round-robin pick: first requesting index at or after the pointer
  logic          found_c;
  logic [PW-1:0] pick_c;
  int unsigned   scan_c;

  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    scan_c  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_c = (32'(ptr_q) + k) % NREQ;
      if (!found_c && req[PW'(scan_c)]) begin
        found_c = 1'b1;
        pick_c  = PW'(scan_c);
      end
    end
  end

  // SCLK edge scheduling; odd edge numbers are leading edges
  logic          edge_c;
  logic [EW-1:0] n_c;
  logic          sample_c;
  logic          shift_c;

  always_comb begin
    edge_c = 1'b0;
    if (state_q == SETUP) begin
      edge_c = (cnt_q == CW'(CLKDIV));
    end else if (state_q == SHIFT) begin
      edge_c = (cnt_q == CW'(CLKDIV - 1)) && (edge_q != EW'(NEDGE));
    end
    n_c      = edge_q + EW'(1);
    sample_c = edge_c && (n_c[0] ^ cpha_q);
    shift_c  = edge_c && !(n_c[0] ^ cpha_q) && (n_c != EW'(NEDGE));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      ss_q      <= '1;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      cpha_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      edge_q    <= '0;
    end else begin
      done_q <= '0;
      if (edge_c) begin
        sclk_q <= ~sclk_q;
        edge_q <= n_c;
      end
      if (sample_c) begin
        rx_q <= {MISO, rx_q[WORDLEN-1:1]};
      end
      if (shift_c) begin
        mosi_q <= tx_q[0];
        tx_q   <= tx_q >> 1;
      end
      unique case (state_q)
        IDLE: begin
          if (found_c) begin
            idx_q   <= pick_c;
            gnt_q   <= NREQ'(1) << pick_c;
            tx_q    <= req_data[32'(pick_c)*WORDLEN +: WORDLEN];
            cpha_q  <= req_mode[32'(pick_c)*2];
            // CPOL applied here so SCLK settles while every SS is still high
            sclk_q  <= req_mode[32'(pick_c)*2 + 1];
            rx_q    <= '0;
            edge_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == '0) begin
            ss_q <= ~gnt_q;
            if (!cpha_q) begin
              mosi_q <= tx_q[0];
              tx_q   <= tx_q >> 1;
            end
          end
          if (edge_c) begin
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          cnt_q <= cnt_q + CW'(1);
          if (edge_c) begin
            cnt_q <= '0;
          end else if ((edge_q == EW'(NEDGE)) && (cnt_q == CW'(CLKDIV - 1))) begin
            cnt_q   <= '0;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(CLKDIV - 1)) begin
            ss_q      <= '1;
            done_q    <= gnt_q;
            rx_data_q <= rx_q;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            ptr_q     <= PW'((32'(idx_q) + 1) % NREQ);
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign SS      = ss_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: a slave model per select line, a
// round-robin reference order, and a monitor that checks every done pulse.
module tb_spi_bus_arbiter;

  localparam int unsigned W   = 8;
  localparam int unsigned N   = 2;
  localparam int unsigned C   = 2;
  localparam int unsigned DW  = N * W;
  localparam int unsigned MW  = 2 * N;
  localparam int          LAT = 2 + (2 * W + 2) * C;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [DW-1:0] req_data = '0;
  logic [MW-1:0] req_mode = '0;
  logic [N-1:0]  gnt, done, SS;
  logic [W-1:0]  rx_data;
  logic          busy, SCLK, MOSI;
  logic          miso = 1'b0;

  spi_bus_arbiter #(.WORDLEN(W), .NREQ(N), .CLKDIV(C)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_mode(req_mode),
    .gnt(gnt), .done(done), .rx_data(rx_data), .busy(busy),
    .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(miso)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int           id;
    logic [W-1:0] rx;
    logic [W-1:0] tx;
  } exp_t;

  exp_t expq[$];

  // Slave configuration (owned by the slaves, independent of req_mode) and records
  logic [1:0]   slave_mode[N];
  logic [W-1:0] slave_word[N];
  int           rec_edges[N];
  logic [W-1:0] rec_cap[N];
  bit           rec_idle_ok[N];
  int           ss_bad = 0;

  // Round configuration consumed by run_round
  int           rem[N];
  logic [W-1:0] dat[N];
  logic [W-1:0] swd[N];
  logic [1:0]   mde[N];
  int           model_ptr = 0;

  // Slave model: watches SS/SCLK just after each clk edge
  initial begin
    logic [N-1:0] pss;
    logic         psclk;
    bit           act, lead;
    int           sid, edges, bitp, nlow, sel;
    logic [W-1:0] cap;
    logic [1:0]   m;
    bit           idle_ok;
    pss = '1; psclk = 1'b0; act = 0; sid = 0; edges = 0; bitp = 0;
    cap = '0; m = '0; idle_ok = 0; lead = 0;
    forever begin
      @(posedge clk);
      #1;
      nlow = 0;
      sel  = 0;
      for (int i = 0; i < N; i++) begin
        if (SS[i] === 1'b0) begin
          nlow++;
          sel = i;
        end
      end
      if (nlow > 1) ss_bad++;
      if (act && nlow == 0) begin
        act              = 0;
        rec_edges[sid]   = edges;
        rec_cap[sid]     = cap;
        rec_idle_ok[sid] = idle_ok && (SCLK === m[1]);
      end else if (!act && nlow == 1 && pss === '1) begin
        act     = 1;
        sid     = sel;
        m       = slave_mode[sel];
        edges   = 0;
        cap     = '0;
        bitp    = 0;
        idle_ok = (SCLK === m[1]);
        if (!m[0]) begin
          miso = slave_word[sel][0];
          bitp = 1;
        end
      end else if (act && SCLK !== psclk) begin
        edges++;
        lead = (SCLK !== m[1]);
        if (lead ^ m[0]) begin
          cap = {MOSI, cap[W-1:1]};
        end else if (bitp < W) begin
          miso = slave_word[sid][bitp];
          bitp++;
        end
      end
      pss   = SS;
      psclk = SCLK;
    end
  end

  // Monitor: pops one expectation per done pulse
  initial begin
    int           cyc, gcyc;
    logic [N-1:0] gprev, gval;
    exp_t         e;
    cyc = 0; gcyc = 0; gprev = '0; gval = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if ((|gnt) && !(|gprev)) begin
        gcyc = cyc;
        gval = gnt;
      end
      gprev = gnt;
      if (|done) begin
        if (expq.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'(0));
        end else begin
          e = expq.pop_front();
          chk("done_id", 32'(done), 32'(1) << e.id);
          chk("gnt_id", 32'(gval), 32'(1) << e.id);
          chk("rx_data", 32'(rx_data), 32'(e.rx));
          chk("mosi_word", 32'(rec_cap[e.id]), 32'(e.tx));
          chk("sclk_edges", 32'(rec_edges[e.id]), 32'(2 * W));
          chk("sclk_idle_cpol", 32'(rec_idle_ok[e.id]), 32'(1));
          chk("latency", 32'(cyc - gcyc + 1), 32'(LAT));
          chk("busy_at_done", 32'(busy), 32'(0));
        end
      end
    end
  end

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += rem[i];
    return s;
  endfunction

  task automatic cfg(input int i, input int n, input logic [1:0] md,
                     input logic [W-1:0] d, input logic [W-1:0] s);
    rem[i] = n;
    mde[i] = md;
    dat[i] = d;
    swd[i] = s;
  endtask

  // Issues one round of requests and predicts the service order
  task automatic run_round(input bit drop_test);
    int   r[N];
    int   cyc, id;
    bit   found;
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_data[i*W +: W] = dat[i];
      req_mode[2*i +: 2] = mde[i];
      slave_mode[i]      = mde[i];
      slave_word[i]      = swd[i];
      r[i]               = rem[i];
    end
    forever begin
      found = 0;
      e     = '{id: 0, rx: '0, tx: '0};
      for (int k = 0; k < N; k++) begin
        id = (model_ptr + k) % N;
        if (!found && r[id] > 0) begin
          found = 1;
          e.id  = id;
          e.rx  = swd[id];
          e.tx  = dat[id];
        end
      end
      if (!found) break;
      expq.push_back(e);
      r[e.id]--;
      model_ptr = (e.id + 1) % N;
    end
    for (int i = 0; i < N; i++) req[i] = (rem[i] > 0);
    cyc = 0;
    while (pending() > 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (done[i] === 1'b1 && rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) req[i] = 1'b0;
        end
      end
      if (drop_test && cyc == 5) begin
        req[0]   = 1'b0;
        req_data = DW'($urandom);
        req_mode = MW'($urandom);
      end
    end
    if (pending() > 0) begin
      chk("round_timeout_pending", 32'(pending()), 32'(0));
      for (int i = 0; i < N; i++) rem[i] = 0;
      req = '0;
      expq.delete();
    end
  endtask

  // Reset pulled low 15 cycles into a transfer
  task automatic reset_mid();
    int cyc;
    @(negedge clk);
    req_data[0 +: W] = 8'hC3;
    req_mode[1:0]    = 2'b01;
    slave_mode[0]    = 2'b01;
    slave_word[0]    = 8'h55;
    req[0]           = 1'b1;
    cyc = 0;
    while (gnt[0] !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_test_grant", 32'(gnt), 32'(1));
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    chk("rst_mid_ss", 32'(SS), 32'({N{1'b1}}));
    chk("rst_mid_sclk", 32'(SCLK), 32'(0));
    chk("rst_mid_gnt", 32'(gnt), 32'(0));
    chk("rst_mid_busy", 32'(busy), 32'(0));
    chk("rst_mid_done", 32'(done), 32'(0));
    rst_n     = 1'b1;
    model_ptr = 0;
    @(negedge clk);
    chk("rst_mid_done_after", 32'(done), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; dat[i] = '0; swd[i] = '0; mde[i] = '0;
      slave_mode[i] = '0; slave_word[i] = '0;
      rec_edges[i] = 0; rec_cap[i] = '0; rec_idle_ok[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_ss", 32'(SS), 32'({N{1'b1}}));
    chk("reset_sclk", 32'(SCLK), 32'(0));
    chk("reset_mosi", 32'(MOSI), 32'(0));
    chk("reset_gnt", 32'(gnt), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_rx_data", 32'(rx_data), 32'(0));
    rst_n = 1'b1;

    cfg(0, 1, 2'd0, 8'hA5, 8'h3C); run_round(0);
    cfg(0, 1, 2'd1, 8'hA5, 8'h3C); run_round(0);
    cfg(0, 1, 2'd2, 8'hA5, 8'h3C); run_round(0);
    cfg(1, 1, 2'd3, 8'hA5, 8'h3C); run_round(0);

    cfg(0, 2, 2'd0, 8'hA5, 8'h3C);
    cfg(1, 2, 2'd0, 8'h5A, 8'hC3);
    run_round(0);

    cfg(0, 1, 2'd0, 8'h81, 8'h7E); run_round(0);
    cfg(1, 1, 2'd2, 8'h42, 8'hBD); run_round(0);

    cfg(0, 1, 2'($urandom_range(0, 3)), 8'h96, 8'h71); run_round(1);

    reset_mid();
    cfg(0, 1, 2'd0, 8'hA5, 8'h3C); run_round(0);

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin
        cfg(i, int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
            W'($urandom), W'($urandom));
      end
      if (pending() == 0) rem[0] = 1;
      run_round(0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (50) @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'(0));
    chk("ss_multi_select", 32'(ss_bad), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

endmodule
